// File: rtl/period_detect.sv
// Rising zero-crossing period detector with hysteresis on a signed sample stream.
// Optional PERIOD_AVG_EN macro: report the mean of the last four measurements.
module period_detect #(
    parameter int              SW         = 24,
    parameter int              PW         = 26,
    parameter logic [SW-1:0]   HYST       = SW'(24'h010000),
    parameter logic [PW-1:0]   MAX_PERIOD = PW'(26'h3FFFFFF)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          sample_valid_i,
    input  logic [SW-1:0] sample_i,
    output logic [PW-1:0] period_o,
    output logic          period_valid_o,
    output logic          locked_o,
    output logic          timeout_o
);

    // state     | meaning
    // IDLE      | detector disabled, measurement discarded
    // SEEK_LOW  | disarmed, waiting for sample < -HYST
    // SEEK_HIGH | armed, waiting for sample >= +HYST (crossing)
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEEK_LOW  = 2'd1,
        SEEK_HIGH = 2'd2
    } state_t;

    localparam logic [PW-1:0]        CNT_ONE  = PW'(1);
    localparam logic signed [SW-1:0] HYST_POS = HYST;
    localparam logic signed [SW-1:0] HYST_NEG = -HYST_POS;

    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          have_ref_q, have_ref_d;
    logic [PW-1:0] period_q, period_d;
    logic          period_valid_q, period_valid_d;
    logic          locked_q, locked_d;
    logic          timeout_q, timeout_d;

    logic signed [SW-1:0] sample_s;
    logic                 below_neg;
    logic                 at_pos;
    logic                 crossing;
    logic                 expire;

    assign sample_s  = $signed(sample_i);
    assign below_neg = (sample_s < HYST_NEG);
    assign at_pos    = (sample_s >= HYST_POS);
    assign crossing  = (state_q == SEEK_HIGH) && at_pos;
    assign expire    = have_ref_q && (cnt_q == MAX_PERIOD);

`ifdef PERIOD_AVG_EN
    logic [3:0][PW-1:0] hist_q, hist_d;
    logic [PW+1:0]      sum_q, sum_d;
    logic [2:0]         fill_q, fill_d;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        have_ref_d     = have_ref_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        timeout_d      = 1'b0;
`ifdef PERIOD_AVG_EN
        hist_d         = hist_q;
        sum_d          = sum_q;
        fill_d         = fill_q;
`endif

        if (!en_i) begin
            state_d    = IDLE;
            cnt_d      = '0;
            have_ref_d = 1'b0;
            locked_d   = 1'b0;
`ifdef PERIOD_AVG_EN
            hist_d     = '0;
            sum_d      = '0;
            fill_d     = '0;
`endif
        end else if (state_q == IDLE) begin
            state_d = SEEK_LOW;
        end else if (sample_valid_i) begin
            if (crossing) begin
                // Crossing takes priority over timeout, so cnt may equal MAX_PERIOD here.
                state_d    = SEEK_LOW;
                cnt_d      = CNT_ONE;
                have_ref_d = 1'b1;
                if (have_ref_q) begin
`ifdef PERIOD_AVG_EN
                    hist_d = {hist_q[2:0], cnt_q};
                    sum_d  = sum_q - {2'b00, hist_q[3]} + {2'b00, cnt_q};
                    fill_d = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
                    if (fill_d == 3'd4) begin
                        period_d       = sum_d[PW+1:2];
                        period_valid_d = 1'b1;
                        locked_d       = 1'b1;
                    end
`else
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    locked_d       = 1'b1;
`endif
                end
            end else if (expire) begin
                state_d    = SEEK_LOW;
                cnt_d      = '0;
                have_ref_d = 1'b0;
                locked_d   = 1'b0;
                timeout_d  = 1'b1;
`ifdef PERIOD_AVG_EN
                hist_d     = '0;
                sum_d      = '0;
                fill_d     = '0;
`endif
            end else begin
                if (have_ref_q) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if ((state_q == SEEK_LOW) && below_neg) begin
                    state_d = SEEK_HIGH;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            have_ref_q     <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            have_ref_q     <= have_ref_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

`ifdef PERIOD_AVG_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q <= '0;
            sum_q  <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            sum_q  <= sum_d;
            fill_q <= fill_d;
        end
    end
`endif

    assign period_o       = period_q;
    assign period_valid_o = period_valid_q;
    assign locked_o       = locked_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_period_detect.sv
// Directed self-checking bench for period_detect (MAX_PERIOD overridden to 1000).
module tb_period_detect;
    localparam int SW = 24;
    localparam int PW = 26;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sv;
    logic [SW-1:0] smp;
    logic [PW-1:0] period;
    logic          pv;
    logic          locked;
    logic          tmo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    period_detect #(
        .SW(SW),
        .PW(PW),
        .HYST(24'h010000),
        .MAX_PERIOD(26'd1000)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .en_i(en),
        .sample_valid_i(sv),
        .sample_i(smp),
        .period_o(period),
        .period_valid_o(pv),
        .locked_o(locked),
        .timeout_o(tmo)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkp(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [SW-1:0] s);
        sv  = v;
        smp = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] saw_val(input int p);
        logic signed [31:0] v;
        v = -32'sd1048575 + p * 21183;
        return v[SW-1:0];
    endfunction

`ifndef PERIOD_AVG_EN
    // Ramp crosses +HYST at phase 53; from a fresh start the first period appears at sample 153.
    task automatic run_saw(input int nsamp, input bit gapped);
        logic exp_pv;
        for (int i = 0; i < nsamp; i++) begin
            if (gapped) begin
                step(1'b0, saw_val((i + 50) % 100));
                chk1("gap_idle_pv", pv, 1'b0);
            end
            step(1'b1, saw_val(i % 100));
            exp_pv = (i >= 153) && ((i % 100) == 53);
            chk1("saw_pv", pv, exp_pv);
            chk1("saw_locked", locked, i >= 153);
            chk1("saw_timeout", tmo, 1'b0);
            if (exp_pv) chkp("saw_period", period, 26'd100);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        sv  = 1'b0;
        smp = '0;
        @(posedge clk);
        #1;
        chkp("rst_period", period, 26'd0);
        chk1("rst_pv", pv, 1'b0);
        chk1("rst_locked", locked, 1'b0);
        chk1("rst_timeout", tmo, 1'b0);
        rst = 1'b0;
        en  = 1'b1;
        step(1'b0, '0);

`ifdef PERIOD_AVG_EN
        step(1'b1, 24'hFE0000);
        for (int m = 0; m < 5; m++) begin
            step(1'b1, 24'h020000);
            chk1("avg_pv", pv, m == 4);
            chk1("avg_locked", locked, m == 4);
            if (m == 4) chkp("avg_period", period, 26'd101);
            if (m < 4) begin
                step(1'b1, 24'hFE0000);
                for (int k = 0; k < ((m == 3) ? 102 : 98); k++) begin
                    step(1'b1, '0);
                    chk1("avg_fill_pv", pv, 1'b0);
                end
            end
        end
`else
        // Continuous sawtooth, stopping mid-period with locked high.
        run_saw(340, 1'b0);

        // One-cycle enable drop drops lock and holds period.
        en = 1'b0;
        step(1'b1, saw_val(40));
        chk1("endrop_locked", locked, 1'b0);
        chk1("endrop_pv", pv, 1'b0);
        chkp("endrop_period_hold", period, 26'd100);
        en = 1'b1;
        step(1'b0, '0);
        run_saw(320, 1'b0);

        // Asynchronous reset mid-ramp, checked before the next clock edge.
        rst = 1'b1;
        #1;
        chkp("async_rst_period", period, 26'd0);
        chk1("async_rst_pv", pv, 1'b0);
        chk1("async_rst_locked", locked, 1'b0);
        chk1("async_rst_timeout", tmo, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, '0);

        run_saw(300, 1'b1);

        // Small alternating noise never arms.
        en = 1'b0;
        step(1'b0, '0);
        en = 1'b1;
        step(1'b0, '0);
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, (i % 2 == 0) ? 24'h008000 : 24'hFF8000);
            chk1("noise_pv", pv, 1'b0);
            chk1("noise_locked", locked, 1'b0);
            chk1("noise_timeout", tmo, 1'b0);
        end

        // Two crossings, then a flat line until timeout.
        run_saw(154, 1'b0);
        for (int k = 1; k <= 1001; k++) begin
            step(1'b1, '0);
            chk1("to_pulse", tmo, k == 1000);
            chk1("to_locked", locked, k < 1000);
            chkp("to_period_hold", period, 26'd100);
        end

        // Crossing exactly when cnt reaches MAX_PERIOD: crossing wins.
        step(1'b1, 24'hFE0000);
        step(1'b1, 24'h020000);
        chk1("max_ref_pv", pv, 1'b0);
        step(1'b1, 24'hFE0000);
        for (int k = 2; k < 1000; k++) begin
            step(1'b1, '0);
            chk1("max_fill_timeout", tmo, 1'b0);
            chk1("max_fill_pv", pv, 1'b0);
        end
        step(1'b1, 24'h020000);
        chk1("max_cross_pv", pv, 1'b1);
        chkp("max_cross_period", period, 26'd1000);
        chk1("max_cross_timeout", tmo, 1'b0);
        chk1("max_cross_locked", locked, 1'b1);

        // Hysteresis boundaries: -HYST does not arm, +HYST triggers.
        step(1'b1, 24'hFF0000);
        step(1'b1, 24'h010000);
        chk1("bnd_neg_no_arm", pv, 1'b0);
        step(1'b1, 24'hFEFFFF);
        step(1'b1, 24'h00FFFF);
        chk1("bnd_below_pos", pv, 1'b0);
        step(1'b1, 24'h010000);
        chk1("bnd_pos_cross_pv", pv, 1'b1);
        chkp("bnd_pos_period", period, 26'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/period_detect.md
Name: period_detect

Overview:
- Measurement-side counterpart to the tone generators: takes a stream of signed 24-bit audio samples and recovers the waveform period, in samples, from successive rising zero crossings with hysteresis.
- Sits on the tone bus after a generator or mixer.
- Used for self-check of generated notes and for pitch readback to the control logic.

Parameters:
- SW, 24: sample width, signed two's complement.
- PW, 26: period output and counter width.
- HYST, 24'h010000: hysteresis threshold, positive magnitude.
- MAX_PERIOD, 26'h3FFFFFF: sample count at which an open measurement times out.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  detector enable; low forces IDLE
- sample_valid  in  1  qualifies sample; one accepted sample per high cycle
- sample  in  SW  signed sample
- period  out  PW  last measured period, in samples
- period_valid  out  1  one-cycle pulse when period updates
- locked  out  1  high while consecutive measurements are valid
- timeout  out  1  one-cycle pulse when an open measurement expires

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, have_ref=0, period=0, period_valid=0, locked=0, timeout=0.
- All outputs are registered. Nothing changes on cycles with sample_valid=0, except the en-low handling below.
- State IDLE: entered whenever en=0, regardless of current state.
  - Clears cnt, have_ref and locked; period holds its last value.
  - Goes to SEEK_LOW on the first cycle with en=1.
- State SEEK_LOW (disarmed): on an accepted sample with signed sample < -HYST, go to SEEK_HIGH.
- State SEEK_HIGH (armed): on an accepted sample with signed sample >= +HYST, a crossing event fires and the state returns to SEEK_LOW.
- Comparisons are signed, full SW width.
- Counting: while have_ref=1, each accepted sample that is not a crossing does cnt <= cnt+1.
- Crossing event:
  - If have_ref=0: have_ref <= 1, cnt <= 1. No output.
  - If have_ref=1: period <= cnt, cnt <= 1, period_valid pulses, locked <= 1.
- Result: for crossings at sample indices i and j, period = j - i.
- Latency: period and period_valid appear the cycle after the clock edge that accepts the crossing sample.
- Timeout: applies to an accepted non-crossing sample with have_ref=1 and cnt == MAX_PERIOD.
  - Effects: timeout pulses, have_ref <= 0, locked <= 0, cnt <= 0, state <= SEEK_LOW; period holds.
- Crossing and timeout on the same sample: the crossing wins and period = MAX_PERIOD. No timeout pulse.
- cnt never wraps; the timeout bounds it.
- Reset or en low in mid-measurement discards the partial count. After re-enable, two crossings are required before the next period_valid.
- Samples on the HYST boundary: exactly +HYST triggers; exactly -HYST does not arm.

Optional Feature:
- Macro: PERIOD_AVG_EN.
- When defined:
  - period reports the mean of the last 4 measurements: a 4-entry history plus a PW+2-bit running sum, output sum>>2 truncated.
  - period_valid and locked assert only once 4 measurements have been collected since the last history clear.
  - History and fill count clear on reset, timeout and en low.
  - period_valid latency is unchanged (1 cycle).
- When undefined: raw per-cycle measurement as described above; no history logic is built.

Test Plan:
- Reset: assert rst mid-ramp with have_ref=1 -> period=0, period_valid=0, locked=0, timeout=0 on the same cycle (asynchronous).
- Ideal sawtooth: ramp -0x0FFFFF..+0x0FFFFF, 100 samples per cycle, sample_valid=1 continuously, en=1 -> first period_valid at the second crossing with period=100, then a pulse every 100 cycles, locked=1.
- Gapped valid: same waveform with sample_valid on alternate cycles -> period=100 (counts samples, not clocks), period_valid every 200 clocks.
- Noise immunity: sample alternating +0x8000/-0x8000 for 1000 samples -> no arm, no period_valid, locked stays 0.
- Timeout: MAX_PERIOD=1000, two crossings, then sample held at 0 -> timeout pulse on the 1000th post-crossing sample, locked falls, period holds 100. Also force a crossing exactly at cnt=1000 -> period=1000, no timeout pulse.
- Enable drop: deassert en for 1 cycle mid-period -> locked=0. After re-enable, the first period_valid occurs only after two further crossings, with period=100.
- With PERIOD_AVG_EN: periods 100,100,100,104 -> first period_valid after the 4th measurement with period=101.
